// File: rtl/keycond_pkg.sv
// Shared types and width helpers for the button conditioner.
package keycond_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        DELAY,
        REPEAT
    } chan_state_t;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: synchroniser, debounce, repeat FSM, sticky command.
module key_channel
    import keycond_pkg::*;
#(
    parameter int DB_TICKS      = 10,
    parameter int REPEAT_DELAY  = 300,
    parameter int REPEAT_PERIOD = 100,
    parameter bit RPT_EN        = 1'b1
) (
    input  logic CLK,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    input  logic ack,
    output logic level,
    output logic press,
    output logic req,
    output logic ovf
);

    localparam int DBW = cnt_w(DB_TICKS);
    localparam int RCW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_TICKS - 1);
    localparam logic [RCW-1:0] DLY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PER_LAST = RCW'(REPEAT_PERIOD - 1);

    logic           s1, s2;
    logic [DBW-1:0] db_cnt;
    logic           flip, rise, fall;
    chan_state_t    state_q, state_d;
    logic [RCW-1:0] rpt_q, rpt_d;
    logic           emit;

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // level changes on the tick that completes DB_TICKS disagreeing samples
    assign flip = tick && (s2 != level) && (db_cnt == DB_LAST);
    assign rise = flip && s2;
    assign fall = flip && !s2;

    always_ff @(posedge CLK) begin
        if (reset) begin
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= rise;
            if (flip) begin
                level  <= s2;
                db_cnt <= '0;
            end else if (tick) begin
                db_cnt <= (s2 != level) ? db_cnt + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= RELEASED;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        emit    = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (rise) begin
                    state_d = DELAY;
                    rpt_d   = '0;
                    emit    = 1'b1;
                end
            end
            DELAY: begin
                if (fall) begin
                    state_d = RELEASED;
                    rpt_d   = '0;
                end else if (tick) begin
                    if (rpt_q == DLY_LAST) begin
                        if (RPT_EN) begin
                            state_d = REPEAT;
                            rpt_d   = '0;
                            emit    = 1'b1;
                        end
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = RELEASED;
                    rpt_d   = '0;
                end else if (tick) begin
                    if (rpt_q == PER_LAST) begin
                        rpt_d = '0;
                        emit  = 1'b1;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RELEASED;
                rpt_d   = '0;
            end
        endcase
    end

    // a new command beats a simultaneous ack
    always_ff @(posedge CLK) begin
        if (reset) begin
            req <= 1'b0;
            ovf <= 1'b0;
        end else if (emit) begin
            req <= 1'b1;
            if (req) ovf <= 1'b1;
        end else if (ack) begin
            req <= 1'b0;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Button input stage: shared sample-tick prescaler feeding per-button channels.
module key_conditioner
    import keycond_pkg::*;
#(
    parameter int               N_BTN         = 3,
    parameter int               TICK_DIV      = 50000,
    parameter int               DB_TICKS      = 10,
    parameter int               REPEAT_DELAY  = 300,
    parameter int               REPEAT_PERIOD = 100,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(3'b011)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [N_BTN-1:0] raw_btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] cmd_req,
    input  logic [N_BTN-1:0] cmd_ack,
    output logic [N_BTN-1:0] cmd_ovf
);

    localparam int PW = cnt_w(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        key_channel #(
            .DB_TICKS      (DB_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .RPT_EN        (REPEAT_MASK[i])
        ) u_ch (
            .CLK   (CLK),
            .reset (reset),
            .tick  (tick),
            .raw   (raw_btn[i]),
            .ack   (cmd_ack[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .req   (cmd_req[i]),
            .ovf   (cmd_ovf[i])
        );
    end

endmodule
